// File: rtl/bus_timer_irq.sv
// Memory-mapped interval timer on the shared 8-bit CPU bus.
// Prescaled tick drives a free counter and a held interrupt request.
module bus_timer_irq #(
    parameter logic [7:0]  BASE_ADDR      = 8'hF0,
    parameter int unsigned TICK_CYCLES    = 50000,
    parameter logic [7:0]  INTERVAL_RESET = 8'd100
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] presc;
    logic [7:0]    timer_value;
    logic [7:0]    ivl_cnt;
    logic [7:0]    interval;
    logic [1:0]    ctrl;
    logic          irq_pending;
    logic [7:0]    rd_data;
    logic          rd_drive;
    logic [7:0]    rd_next;

    logic [7:0] off;
    logic       in_range;
    logic       wr_en;
    logic       rd_en;
    logic       wr_intv;
    logic       wr_ctrl;
    logic       clr;
    logic       cnt_en;
    logic       irq_en;
    logic       tick;
    logic       irq_event;

    assign off      = BUS_ADDR - BASE_ADDR;
    assign in_range = (off < 8'd4);
    assign wr_en    = BUS_WE && in_range;
    assign rd_en    = !BUS_WE && in_range;
    assign wr_intv  = wr_en && (off[1:0] == 2'd1);
    assign wr_ctrl  = wr_en && (off[1:0] == 2'd2);
    assign clr      = wr_en && (off[1:0] == 2'd3);
    assign irq_en   = ctrl[0];
    assign cnt_en   = ctrl[1];
    assign tick     = cnt_en && (presc == TICK_LAST);

    // CLEAR on a tick edge suppresses the event along with the counts
    assign irq_event = tick && !clr && (interval != 8'd0)
                       && (ivl_cnt == interval - 8'd1);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            presc       <= '0;
            timer_value <= 8'd0;
            ivl_cnt     <= 8'd0;
        end else if (clr) begin
            presc       <= '0;
            timer_value <= 8'd0;
            ivl_cnt     <= 8'd0;
        end else if (cnt_en) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                timer_value <= timer_value + 8'd1;
                if (interval == 8'd0 || irq_event)
                    ivl_cnt <= 8'd0;
                else
                    ivl_cnt <= ivl_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            interval <= INTERVAL_RESET;
            ctrl     <= 2'b11;
        end else begin
            if (wr_intv)
                interval <= BUS_DATA;
            if (wr_ctrl)
                ctrl <= BUS_DATA[1:0];
        end
    end

    // Event beats a coincident ACK; disabling IRQ_EN beats both
    always_ff @(posedge CLK) begin
        if (!RESET)
            irq_pending <= 1'b0;
        else if (wr_ctrl && !BUS_DATA[0])
            irq_pending <= 1'b0;
        else if (irq_event && irq_en)
            irq_pending <= 1'b1;
        else if (BUS_INTERRUPT_ACK)
            irq_pending <= 1'b0;
    end

    always_comb begin
        rd_next = 8'h00;
        unique case (off[1:0])
            2'd0: rd_next = timer_value;
            2'd1: rd_next = interval;
            2'd2: rd_next = {6'b0, ctrl};
            2'd3: rd_next = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_drive <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            rd_drive <= rd_en;
            if (rd_en)
                rd_data <= rd_next;
        end
    end

    assign BUS_DATA            = rd_drive ? rd_data : 8'bz;
    assign BUS_INTERRUPT_RAISE = irq_pending;

endmodule

// File: tb/tb_bus_timer_irq.sv
// Bench for bus_timer_irq: vector table, directed corner sequences
// and random traffic against a tick-count reference model.
module tb_bus_timer_irq;

    localparam int T = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic       we;
    logic       ack;
    logic       raise;
    logic [7:0] cpu_do;
    logic       cpu_oe;
    tri1  [7:0] bus_data;

    assign bus_data = cpu_oe ? cpu_do : 8'bz;

    bus_timer_irq #(
        .BASE_ADDR(8'hF0),
        .TICK_CYCLES(T),
        .INTERVAL_RESET(8'd100)
    ) dut (
        .CLK(clk),
        .RESET(rst_n),
        .BUS_DATA(bus_data),
        .BUS_ADDR(addr),
        .BUS_WE(we),
        .BUS_INTERRUPT_RAISE(raise),
        .BUS_INTERRUPT_ACK(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference state: enabled cycles since clear, interval position
    int m_run, m_ivl, m_intv, m_ctrl, m_pend, m_drv, m_rdata;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_ivl = 0; m_intv = 100;
        m_ctrl = 3; m_pend = 0; m_drv = 0; m_rdata = 0;
    endtask

    task automatic step(input bit r_n, input bit w,
                        input logic [7:0] a, input logic [7:0] wd,
                        input bit k);
        bit inr, tick, clr, ev, en;
        int r, val;
        if (!r_n) begin
            m_reset();
        end else begin
            inr = (a >= 8'hF0) && (a <= 8'hF3);
            r = int'(a) - 32'hF0;
            en = (m_ctrl & 2) != 0;
            case (r)
                0: val = (m_run / T) % 256;
                1: val = m_intv;
                2: val = m_ctrl;
                default: val = 0;
            endcase
            tick = en && ((m_run % T) == T - 1);
            clr = w && inr && (r == 3);
            ev = 0;
            if (clr) begin
                m_run = 0;
                m_ivl = 0;
            end else if (en) begin
                m_run++;
                if (tick) begin
                    if (m_intv == 0) m_ivl = 0;
                    else if (m_ivl == m_intv - 1) begin
                        m_ivl = 0;
                        ev = 1;
                    end else m_ivl = (m_ivl + 1) % 256;
                end
            end
            if (w && inr && r == 2 && !wd[0]) m_pend = 0;
            else if (ev && (m_ctrl & 1) != 0) m_pend = 1;
            else if (k) m_pend = 0;
            m_drv = (!w && inr) ? 1 : 0;
            if (m_drv != 0) m_rdata = val;
            if (w && inr && r == 1) m_intv = int'(wd);
            if (w && inr && r == 2) m_ctrl = int'(wd) & 3;
        end
    endtask

    task automatic cycle(input bit w, input logic [7:0] a,
                         input logic [7:0] wd, input bit k);
        we = w; addr = a; cpu_do = wd; cpu_oe = w; ack = k;
        @(posedge clk);
        step(rst_n, w, a, wd, k);
        cyc++;
        #1;
        chk("raise", {7'b0, raise}, 8'(m_pend));
        if (!cpu_oe)
            chk("bus", bus_data, (m_drv != 0) ? 8'(m_rdata) : 8'hFF);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cycle(1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        cycle(1'b0, a, 8'h00, 1'b0);
        v = bus_data;
        idle(1);
    endtask

    task automatic wait_raise(output int at);
        bit ok;
        ok = 0;
        at = cyc;
        for (int n = 0; n < 60; n++) begin
            idle(1);
            if (raise) begin
                ok = 1;
                at = cyc;
                break;
            end
        end
        chk("irq_timeout", {7'b0, ok}, 8'h01);
    endtask

    typedef struct {
        bit         rst;
        bit         w;
        logic [7:0] a;
        logic [7:0] wd;
        bit         k;
        bit         raise;
        logic [7:0] bus;
        bit         chk_bus;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] v1, v2;
        int at, prev;
        bit prev_rd;

        m_reset();
        rst_n = 1'b0; we = 0; addr = 0; cpu_do = 0; cpu_oe = 0; ack = 0;

        tbl.push_back('{0, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 1});
        tbl.push_back('{0, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 1});
        tbl.push_back('{0, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 1});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 1});
        tbl.push_back('{1, 0, 8'hF1, 8'h00, 0, 0, 8'h64, 1});
        tbl.push_back('{1, 0, 8'hF2, 8'h00, 0, 0, 8'h03, 1});
        tbl.push_back('{1, 0, 8'hF0, 8'h00, 0, 0, 8'h00, 1});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 1});
        tbl.push_back('{1, 1, 8'hEF, 8'h55, 0, 0, 8'hFF, 0});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 1});
        tbl.push_back('{1, 1, 8'hF4, 8'hAA, 0, 0, 8'hFF, 0});
        tbl.push_back('{1, 0, 8'hEF, 8'h00, 0, 0, 8'hFF, 1});
        tbl.push_back('{1, 0, 8'hF4, 8'h00, 0, 0, 8'hFF, 1});
        tbl.push_back('{1, 0, 8'hF1, 8'h00, 0, 0, 8'h64, 1});
        tbl.push_back('{1, 0, 8'hF2, 8'h00, 0, 0, 8'h03, 1});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 1});

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst;
            cycle(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].k);
            chk("tbl_raise", {7'b0, raise}, {7'b0, tbl[i].raise});
            if (tbl[i].chk_bus)
                chk("tbl_bus", bus_data, tbl[i].bus);
        end

        // Periodic IRQ every 3 ticks, ACK two cycles after rise
        wr(8'hF1, 8'd3);
        wr(8'hF3, 8'h00);
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_raise(at);
            if (i > 0) chk("period", 8'(at - prev), 8'd12);
            prev = at;
            cycle(1'b0, 8'hF0, 8'h00, 1'b0);
            chk("timer_at_irq", bus_data, 8'(3 * (i + 1)));
            cycle(1'b0, 8'h00, 8'h00, 1'b1);
            chk("ack_drop", {7'b0, raise}, 8'h00);
        end

        // ACK colliding with an event
        wr(8'hF1, 8'd1);
        wr(8'hF3, 8'h00);
        idle(7);
        chk("pend_before", {7'b0, raise}, 8'h01);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        chk("collide", {7'b0, raise}, 8'h01);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        chk("lone_ack", {7'b0, raise}, 8'h00);

        // Counting disabled freezes timer and IRQ
        wr(8'hF2, 8'h01);
        rd(8'hF0, v1);
        idle(40);
        rd(8'hF0, v2);
        chk("frozen", v2, v1);
        chk("frozen_irq", {7'b0, raise}, 8'h00);

        // IRQ disable drops a pending request
        wr(8'hF2, 8'h03);
        wait_raise(at);
        wr(8'hF2, 8'h02);
        chk("irq_dis", {7'b0, raise}, 8'h00);
        rd(8'hF0, v1);
        idle(20);
        rd(8'hF0, v2);
        chk("advance", {7'b0, v2 != v1}, 8'h01);
        chk("no_irq", {7'b0, raise}, 8'h00);

        // 256 ticks wrap TIMER_VALUE to zero
        wr(8'hF2, 8'h03);
        wr(8'hF1, 8'd0);
        wr(8'hF3, 8'h00);
        idle(256 * T);
        rd(8'hF0, v1);
        chk("wrap", v1, 8'h00);

        // CLEAR on a tick edge wins over the event
        wr(8'hF1, 8'd1);
        wr(8'hF3, 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        idle(2);
        wr(8'hF3, 8'h00);
        chk("clr_tick", {7'b0, raise}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("clr_noev", {7'b0, raise}, 8'h00);
        end
        rd(8'hF0, v1);
        chk("clr_timer", v1, 8'h00);

        // Random traffic against the model
        prev_rd = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a, d;
            bit w, k;
            case ($urandom_range(0, 6))
                0: a = 8'hEF;
                1: a = 8'hF0;
                2: a = 8'hF1;
                3: a = 8'hF2;
                4: a = 8'hF3;
                5: a = 8'hF4;
                default: a = 8'h00;
            endcase
            w = !prev_rd && ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            if (a == 8'hF1) d = 8'($urandom_range(0, 6));
            if (a == 8'hF2 && $urandom_range(0, 2) != 0) d = d | 8'h03;
            k = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            cycle(w, a, d, k);
            prev_rd = rst_n && !w && a >= 8'hF0 && a <= 8'hF3;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
